// File: rtl/ocp_burst_master_if.sv
// ocp_burst_master_if: OCP 3.0 burst master port bundle
interface ocp_burst_master_if #(
    parameter int MADDR_WIDTH = 64,
    parameter int MDATA_WIDTH = 8,
    parameter int BURST_WIDTH = 4
);
    logic [2:0]             MCmd;
    logic [MADDR_WIDTH-1:0] MAddr;
    logic [BURST_WIDTH:0]   MBurstLength;
    logic [MDATA_WIDTH-1:0] MData;
    logic                   MDataValid;
    logic                   MDataLast;
    logic                   MRespAccept;
    logic                   SCmdAccept;
    logic                   SDataAccept;
    logic [1:0]             SResp;
    logic [MDATA_WIDTH-1:0] SData;
    modport master (
        output MCmd, MAddr, MBurstLength, MData, MDataValid, MDataLast, MRespAccept,
        input  SCmdAccept, SDataAccept, SResp, SData
    );
    modport slave (
        input  MCmd, MAddr, MBurstLength, MData, MDataValid, MDataLast, MRespAccept,
        output SCmdAccept, SDataAccept, SResp, SData
    );
endinterface

// File: rtl/ocp_burst_master.sv
// ocp_burst_master: bridge request -> OCP precise-burst master (WR/WRNP/RD).
// Define OCP_RESP_TIMEOUT_EN to abort RESP/RRESP after TIMEOUT_CYCLES idle enabled cycles.
module ocp_burst_master #(
    parameter int MADDR_WIDTH    = 64,
    parameter int MDATA_WIDTH    = 8,
    parameter int BURST_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   EnableClk,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic                   req_posted,
    input  logic [MADDR_WIDTH-1:0] req_addr,
    input  logic [BURST_WIDTH-1:0] req_len,
    input  logic [MDATA_WIDTH-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [MDATA_WIDTH-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   done,
    output logic                   err,
    ocp_burst_master_if.master     ocp
);
    typedef enum logic [2:0] {IDLE, WCMD, RESP, RCMD, RRESP} state_t;
    state_t state, state_n;
    logic [MADDR_WIDTH-1:0] addr_q;
    logic [BURST_WIDTH-1:0] len_q, cnt;
    logic [MDATA_WIDTH-1:0] rd_data_q;
    logic posted_q, cmd_done, data_done, err_q;
    logic rd_valid_q, done_q, done_err_q;
    logic cmd_phase, cmd_acc, wbeat, rbeat, last, resp_st, fin, fin_err, tmo_hit;
    assign last      = cnt == len_q;
    assign resp_st   = state == RESP || state == RRESP;
    assign cmd_phase = (state == WCMD && !cmd_done) || state == RCMD;
    assign cmd_acc   = cmd_phase && EnableClk && ocp.SCmdAccept;
    assign wbeat     = ocp.MDataValid && wr_ready;
    assign rbeat     = state == RRESP && EnableClk && ocp.SResp != 2'b00;
    assign req_ready = state == IDLE && EnableClk;
    assign wr_ready  = state == WCMD && !data_done && EnableClk && ocp.SDataAccept;
    assign ocp.MCmd  = state == RCMD ? 3'b010 :
                       (state == WCMD && !cmd_done) ? (posted_q ? 3'b001 : 3'b101) : 3'b000;
    assign ocp.MAddr        = cmd_phase ? addr_q : '0;
    assign ocp.MBurstLength = cmd_phase ? (BURST_WIDTH+1)'(len_q) + (BURST_WIDTH+1)'(1) : '0;
    assign ocp.MData        = wr_data;
    assign ocp.MDataValid   = state == WCMD && !data_done && wr_valid;
    assign ocp.MDataLast    = ocp.MDataValid && last;
    assign ocp.MRespAccept  = resp_st;
    // Pulses raised on a disabled cycle are held until the next enabled one.
    assign rd_valid = rd_valid_q && EnableClk;
    assign done     = done_q && EnableClk;
    assign err      = done && done_err_q;
    assign rd_data  = rd_data_q;
`ifdef OCP_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = resp_st && EnableClk && ocp.SResp == 2'b00 && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge Clk) begin
        if (reset)
            tmo_cnt <= '0;
        else if (EnableClk)
            tmo_cnt <= (resp_st && ocp.SResp == 2'b00 && !tmo_hit) ? tmo_cnt + TW'(1) : '0;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif
    always_comb begin
        state_n = state;
        fin     = 1'b0;
        fin_err = 1'b0;
        case (state)
            IDLE:  if (req_valid && EnableClk) state_n = req_write ? WCMD : RCMD;
            WCMD:  if ((cmd_done || cmd_acc) && (data_done || (wbeat && last))) begin
                       fin     = posted_q;
                       state_n = posted_q ? IDLE : RESP;
                   end
            RESP:  if (EnableClk && ocp.SResp != 2'b00) begin
                       fin     = 1'b1;
                       fin_err = ocp.SResp != 2'b01;
                       state_n = IDLE;
                   end
            RCMD:  if (cmd_acc) state_n = RRESP;
            RRESP: if (rbeat && last) begin
                       fin     = 1'b1;
                       fin_err = err_q || ocp.SResp[1];
                       state_n = IDLE;
                   end
            default: state_n = IDLE;
        endcase
        if (tmo_hit) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            state_n = IDLE;
        end
    end
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            rd_data_q  <= '0;
            posted_q   <= 1'b0;
            cmd_done   <= 1'b0;
            data_done  <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else if (EnableClk) begin
            state      <= state_n;
            rd_valid_q <= rbeat;
            done_q     <= fin;
            done_err_q <= fin_err;
            if (state == IDLE && req_valid) begin
                addr_q    <= req_addr;
                len_q     <= req_len;
                posted_q  <= req_posted;
                cnt       <= '0;
                err_q     <= 1'b0;
                cmd_done  <= 1'b0;
                data_done <= 1'b0;
            end
            if (cmd_acc) cmd_done <= 1'b1;
            if ((wbeat || rbeat) && !last) cnt <= cnt + BURST_WIDTH'(1);
            if (wbeat && last) data_done <= 1'b1;
            if (rbeat) begin
                rd_data_q <= ocp.SData;
                err_q     <= err_q || ocp.SResp[1];
            end
        end
    end
endmodule

// File: tb/tb_ocp_burst_master.sv
// tb_ocp_burst_master: table of bursts against a reactive OCP slave with data scoreboards
module tb_ocp_burst_master;
    logic        Clk = 1'b0, reset = 1'b1, EnableClk = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_posted = 1'b0;
    logic [63:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [7:0]  wr_data = '0, rd_data;
    logic        wr_valid = 1'b0, wr_ready, rd_valid, done, err;
    ocp_burst_master_if #(.MADDR_WIDTH(64), .MDATA_WIDTH(8), .BURST_WIDTH(4)) bus();
    ocp_burst_master #(.MADDR_WIDTH(64), .MDATA_WIDTH(8), .BURST_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .Clk(Clk), .reset(reset), .EnableClk(EnableClk),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_posted(req_posted),
        .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .ocp(bus)
    );
    always #5 Clk = ~Clk;
    typedef struct {
        bit wr; bit posted; logic [63:0] addr; logic [3:0] len; logic [7:0] base;
        int cmd_dly; int gap; int err_beat; logic [1:0] ecode; bit tog;
        logic [2:0] exp_cmd; bit exp_err;
    } txn_t;
    txn_t tbl[7];
    logic [7:0] wq[$], rq[$];
    int passed = 0, total = 0, resp_cyc = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic idle_inputs();
        req_valid = 1'b0; wr_valid = 1'b0; EnableClk = 1'b1;
        bus.SCmdAccept = 1'b0; bus.SDataAccept = 1'b0; bus.SResp = 2'b00; bus.SData = '0;
    endtask
    task automatic run_txn(input txn_t t, input int abort);
        int cyc = 0, wsent = 0, rbeats = 0, rissued = 0, gapc = 0, cmdc = 0, last_hs = -10;
        bit acc = 0, fin = 0;
        logic [7:0] e;
        resp_cyc = 0;
        if (t.wr) for (int i = 0; i <= int'(t.len); i++) wq.push_back(t.base + 8'(i));
        while (!fin && cyc < 400) begin
            @(negedge Clk);
            EnableClk = t.tog ? (cyc % 2 == 0) : 1'b1;
            req_valid = !acc; req_write = t.wr; req_posted = t.posted; req_addr = t.addr; req_len = t.len;
            wr_valid = t.wr && acc; wr_data = t.base + 8'(wsent);
            bus.SCmdAccept = cmdc >= t.cmd_dly; bus.SDataAccept = 1'b1;
            bus.SResp = 2'b00; bus.SData = '0;
            if (bus.MRespAccept && EnableClk && t.gap < 100) begin
                if (gapc == t.gap) begin
                    gapc = 0;
                    bus.SResp = (rissued == t.err_beat) ? t.ecode : 2'b01;
                    bus.SData = t.base + 8'(rissued);
                    if (!t.wr) rq.push_back(bus.SData);
                    rissued++;
                    last_hs = cyc;
                end else gapc++;
            end
            #1;
            if (EnableClk && req_valid && req_ready) acc = 1;
            if (bus.MRespAccept) resp_cyc++;
            if (bus.MCmd != 3'b000) begin
                chk("mcmd", bus.MCmd, t.exp_cmd);
                chk("mburstlength", bus.MBurstLength, 64'(t.len) + 1);
                chk("maddr", bus.MAddr, t.addr);
                cmdc++;
                if (EnableClk && bus.SCmdAccept && t.wr) last_hs = cyc;
            end
            if (t.wr && t.posted && acc) chk("respaccept_posted", bus.MRespAccept, 0);
            if (EnableClk && wr_valid && wr_ready) begin
                e = wq.pop_front();
                chk("wdata", bus.MData, e);
                chk("wlast", bus.MDataLast, wsent == int'(t.len));
                wsent++;
                last_hs = cyc;
            end
            if (rd_valid) begin
                if (rq.size() == 0) chk("rd_unexpected", 1, 0);
                else begin e = rq.pop_front(); chk("rdata", rd_data, e); end
                rbeats++;
            end
            if (done) begin
                fin = 1;
                chk("err", err, t.exp_err);
                chk("beats", t.wr ? wsent : rbeats, 64'(t.len) + 1);
                if (!t.tog && t.gap < 100) chk("done_latency", cyc - last_hs, 1);
                if (!t.tog && t.wr) chk("cmd_cycles", cmdc, t.cmd_dly + 1);
            end
            if (abort >= 0 && rissued == abort) fin = 1;
            cyc++;
        end
        if (!fin) chk("burst_timeout", 0, 1);
        if (abort < 0) begin
            @(negedge Clk);
            idle_inputs();
            #1;
            chk("done_pulse", done, 0);
            chk("rdvalid_after", rd_valid, 0);
            chk("queues_empty", wq.size() + rq.size(), 0);
        end
    endtask
    initial begin
        tbl[0] = '{1, 1, 64'h1000, 4'd3, 8'hA1, 0, 0, -1, 2'b00, 0, 3'b001, 0};
        tbl[1] = '{1, 0, 64'h2000, 4'd0, 8'h55, 3, 2, 0, 2'b11, 0, 3'b101, 1};
        tbl[2] = '{0, 0, 64'h3000, 4'd7, 8'h10, 0, 1, -1, 2'b00, 0, 3'b010, 0};
        tbl[3] = '{0, 0, 64'h4000, 4'd1, 8'h20, 0, 0, 0, 2'b10, 0, 3'b010, 1};
        tbl[4] = '{1, 1, 64'h5000, 4'd2, 8'hC0, 0, 0, -1, 2'b00, 1, 3'b001, 0};
        tbl[5] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 4'd15, 8'h00, 1, 0, -1, 2'b00, 0, 3'b101, 0};
        tbl[6] = '{0, 0, 64'h8000_0000_0000_0040, 4'd15, 8'h60, 2, 0, 15, 2'b11, 1, 3'b010, 1};
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mcmd", bus.MCmd, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_respaccept", bus.MRespAccept, 0);
        chk("rst_wr_ready", wr_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) run_txn(tbl[i], -1);
        // reset mid-read after two of four beats
        begin
            txn_t a;
            bit saw_done = 0;
            a = tbl[2];
            a.len = 4'd3; a.gap = 0;
            run_txn(a, 2);
            @(negedge Clk);
            idle_inputs();
            reset = 1'b1;
            @(negedge Clk);
            #1;
            chk("abort_mcmd", bus.MCmd, 0);
            chk("abort_respaccept", bus.MRespAccept, 0);
            chk("abort_rd_valid", rd_valid, 0);
            chk("abort_rd_data", rd_data, 0);
            chk("abort_done", done, 0);
            chk("abort_req_ready", req_ready, 1);
            reset = 1'b0;
            rq.delete();
            repeat (4) begin
                @(negedge Clk);
                #1;
                if (done) saw_done = 1;
            end
            chk("abort_no_done", saw_done, 0);
            run_txn(tbl[2], -1);
        end
`ifdef OCP_RESP_TIMEOUT_EN
        begin
            txn_t t;
            t = tbl[1];
            t.gap = 1000; t.cmd_dly = 0;
            run_txn(t, -1);
            chk("timeout_resp_cycles", resp_cyc, 16);
        end
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ocp_burst_master.md
Name: ocp_burst_master

Overview:
- Parametrised successor to the single-beat OCP master FSM.
- Bridges the PCIe-side request interface to an OCP 3.0 master port with configurable address and data widths.
- Adds precise bursts (1..2^BURST_WIDTH beats), non-posted writes with response tracking, multi-beat read response collection, and error reporting.
- Sits between the PCIe bridge logic and the OCP interconnect.

Parameters:
MADDR_WIDTH, 64, OCP address width
MDATA_WIDTH, 8, OCP/bridge data width
BURST_WIDTH, 4, width of req_len; max burst = 2^BURST_WIDTH beats
TIMEOUT_CYCLES, 256, response timeout in enabled cycles (used only with OCP_RESP_TIMEOUT_EN)

Ports:
Clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
EnableClk  in  1  OCP clock enable; all OCP handshakes and state changes qualified by it
req_valid  in  1  bridge request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_posted  in  1  write only: 1 = WR (posted), 0 = WRNP
req_addr  in  MADDR_WIDTH  burst start address
req_len  in  BURST_WIDTH  beats minus 1
wr_data  in  MDATA_WIDTH  write beat data
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat consumed
rd_data  out  MDATA_WIDTH  read beat data
rd_valid  out  1  read beat strobe, one Clk cycle
done  out  1  burst complete pulse, one Clk cycle
err  out  1  valid with done; 1 if any FAIL/ERR response (or timeout)
SCmdAccept  in  1  slave command accept
SDataAccept  in  1  slave data accept
SResp  in  2  NULL=00, DVA=01, FAIL=10, ERR=11
SData  in  MDATA_WIDTH  slave read data
MCmd  out  3  IDLE=000, WR=001, RD=010, WRNP=101
MAddr  out  MADDR_WIDTH  latched start address
MBurstLength  out  BURST_WIDTH+1  req_len+1 during command phase, else 0
MData  out  MDATA_WIDTH  = wr_data
MDataValid  out  1  write data phase valid
MDataLast  out  1  final write beat
MRespAccept  out  1  high in RESP and RRESP states

Behaviour:
- Reset: state IDLE. All outputs 0, except req_ready = EnableClk. Beat counter, latched fields and sticky error cleared.
- Reset mid-burst: aborts immediately to IDLE; no done pulse; partial burst discarded.
- EnableClk low: state, counters and latches frozen; no handshake counts; rd_valid/done never asserted.
- IDLE:
  - req_ready = EnableClk.
  - On accept: latch addr, len, write, posted; clear beat counter and sticky err.
  - Next state is WCMD if write, else RCMD.
- WCMD (command and data phases concurrent):
  - MCmd = WR or WRNP; MAddr and MBurstLength driven until SCmdAccept is sampled.
  - cmd_done flag is set on accept; MCmd then returns to IDLE.
  - Data phase: MDataValid = wr_valid while beats remain; wr_ready = SDataAccept & EnableClk & beats remain.
  - Beat counter increments per transfer. MDataLast = MDataValid & (count == len).
  - Once cmd_done and all len+1 beats are transferred (same-cycle completion allowed):
    - WR: done pulse, err = 0, back to IDLE.
    - WRNP: go to RESP.
- RESP:
  - First non-NULL SResp ends the burst: done pulse; err = (SResp != DVA); back to IDLE.
- RCMD:
  - MCmd = RD with MAddr and MBurstLength.
  - On SCmdAccept: go to RRESP.
- RRESP:
  - Each non-NULL SResp is one beat: rd_valid = 1, rd_data = SData (registered, one cycle latency).
  - FAIL/ERR sets sticky err; the beat is still counted.
  - After beat len+1: done pulse with err = sticky, back to IDLE the same cycle.
- Latency: done asserts the cycle after the completing handshake. A new request may be accepted the cycle after done.
- req_len = 2^BURST_WIDTH-1 gives the maximum burst. Beat counter must not wrap before completion (width BURST_WIDTH).
- Undefined SCmdAccept/SResp outside the relevant states is ignored.

Optional Feature:
OCP_RESP_TIMEOUT_EN:
- Defined: a counter runs while in RESP or RRESP on enabled cycles with SResp == NULL. It clears on any non-NULL response.
- When the counter reaches TIMEOUT_CYCLES: done pulse with err = 1, return to IDLE; late responses are ignored.
- Undefined: no counter; RESP/RRESP wait indefinitely.

Test Plan:
- Posted write, len = 3, addr 0x1000, data 0xA1..0xA4, SCmdAccept/SDataAccept always 1 -> MCmd = WR, MBurstLength = 4, 4 beats, MDataLast on 0xA4, done with err = 0, no MRespAccept.
- WRNP, len = 0, SCmdAccept delayed 3 cycles, SResp = ERR two cycles after data -> MCmd held WRNP 4 cycles, done with err = 1.
- Read, len = 7, SResp DVA with SData 0x10..0x17 and NULL gaps between beats -> 8 rd_valid pulses carrying 0x10..0x17, done after the eighth, err = 0.
- Read, len = 1, first response FAIL -> 2 rd_valid pulses, done with err = 1.
- EnableClk toggled every other cycle during a write len = 2 -> no beats on disabled cycles, exactly 3 transfers, identical data.
- Reset asserted mid-read after 2 of 4 beats -> all outputs 0 next cycle, no done; a new request is accepted normally. With OCP_RESP_TIMEOUT_EN and TIMEOUT_CYCLES = 16, WRNP with no response -> done with err = 1 after 16 enabled cycles.
